// File: rtl/frame_pkg.sv
// Shared constants and state encoding for the frame sequencer and its divider.
// Draw-engine modes, game status codes and the FSM state type live here.
package frame_pkg;

    localparam logic [1:0] MODE_ERASE  = 2'b00;
    localparam logic [1:0] MODE_SPRITE = 2'b01;
    localparam logic [1:0] MODE_CLEAR  = 2'b10;
    localparam logic [1:0] MODE_SCREEN = 2'b11;

    localparam logic [1:0] ST_PLAY  = 2'b00;
    localparam logic [1:0] ST_WIN   = 2'b01;
    localparam logic [1:0] ST_LOSE  = 2'b10;
    localparam logic [1:0] ST_TITLE = 2'b11;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_ERASE  = 3'd2,
        S_SPRITE = 3'd3,
        S_CLEAR  = 3'd4,
        S_SCREEN = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // States that own the draw engine and issue exactly one command.
    function automatic logic is_cmd_state(input state_t s);
        return (s == S_ERASE) || (s == S_SPRITE) || (s == S_CLEAR) || (s == S_SCREEN);
    endfunction

    function automatic logic [1:0] state_mode(input state_t s);
        case (s)
            S_SPRITE: return MODE_SPRITE;
            S_CLEAR:  return MODE_CLEAR;
            S_SCREEN: return MODE_SCREEN;
            default:  return MODE_ERASE;
        endcase
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame divider: counts 0..FRAME_DIV-1 and flags the last count
// as a one-cycle tick. Runs independently of the sequencer state.
module frame_tick_gen #(
    parameter int FRAME_DIV = 833333,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == LAST);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Frame scheduler: per tick, latch the game inputs and sequence
// clear/erase/sprite/screen draw commands, then pulse sync to game logic.
module frame_sequencer
    import frame_pkg::*;
#(
    parameter int FRAME_DIV = 833333,
    parameter int CNT_W     = 20,
    parameter int X_W       = 8,
    parameter int Y_W       = 7
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [1:0]     game_status,
    input  logic           bypass_erase,
    input  logic [X_W-1:0] prev_x,
    input  logic [X_W-1:0] curr_x,
    input  logic [Y_W-1:0] curr_y,
    input  logic           draw_done,
    output logic           draw_start,
    output logic [1:0]     draw_mode,
    output logic [X_W-1:0] draw_x,
    output logic [Y_W-1:0] draw_y,
    output logic           sync,
    output logic           busy,
    output logic           overrun
);

    state_t state;
    state_t state_nxt;

    logic tick;
    logic pending;

    logic [1:0]     last_status;
    logic [1:0]     lat_status;
    logic           lat_bypass;
    logic [X_W-1:0] lat_prev_x;
    logic [X_W-1:0] lat_curr_x;
    logic [Y_W-1:0] lat_curr_y;

    // Frame view of the inputs: live during LATCH (registers update at its
    // exit edge), latched copies for the rest of the frame.
    logic [1:0]     f_status;
    logic           f_bypass;
    logic [X_W-1:0] f_prev_x;
    logic [X_W-1:0] f_curr_x;
    logic [Y_W-1:0] f_curr_y;

    logic           done_ok;
    logic           cmd_go;
    logic [1:0]     cmd_mode;
    logic [X_W-1:0] cmd_x;
    logic [Y_W-1:0] cmd_y;

    frame_tick_gen #(
        .FRAME_DIV (FRAME_DIV),
        .CNT_W     (CNT_W)
    ) u_tick_gen (
        .clk    (clk),
        .resetn (resetn),
        .tick   (tick)
    );

    assign f_status = (state == S_LATCH) ? game_status  : lat_status;
    assign f_bypass = (state == S_LATCH) ? bypass_erase : lat_bypass;
    assign f_prev_x = (state == S_LATCH) ? prev_x       : lat_prev_x;
    assign f_curr_x = (state == S_LATCH) ? curr_x       : lat_curr_x;
    assign f_curr_y = (state == S_LATCH) ? curr_y       : lat_curr_y;

    // A done coincident with our own strobe belongs to no command of ours.
    assign done_ok = draw_done && !draw_start;

    assign sync = (state == S_DONE);
    assign busy = (state != S_IDLE);

    // NOTE: every always_comb output gets a default first, so no path through
    // the case statement can leave a value held and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (tick || pending) state_nxt = S_LATCH;
            end
            S_LATCH: begin
                if (f_status != last_status)                 state_nxt = S_CLEAR;
                else if (f_status == ST_PLAY && !f_bypass)   state_nxt = S_ERASE;
                else if (f_status == ST_PLAY)                state_nxt = S_SPRITE;
                else                                         state_nxt = S_DONE;
            end
            S_ERASE: begin
                if (done_ok) state_nxt = S_SPRITE;
            end
            S_SPRITE: begin
                if (done_ok) state_nxt = S_DONE;
            end
            S_CLEAR: begin
                if (done_ok) state_nxt = (f_status == ST_PLAY) ? S_SPRITE : S_SCREEN;
            end
            S_SCREEN: begin
                if (done_ok) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Command for the state being entered; issued only on a real state change.
    always_comb begin
        cmd_go   = is_cmd_state(state_nxt) && (state_nxt != state);
        cmd_mode = state_mode(state_nxt);
        cmd_x    = '0;
        cmd_y    = '0;
        case (state_nxt)
            S_ERASE: begin
                cmd_x = f_prev_x;
                cmd_y = f_curr_y;
            end
            S_SPRITE: begin
                cmd_x = f_curr_x;
                cmd_y = f_curr_y;
            end
            default: begin
                cmd_x = '0;
                cmd_y = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            draw_start  <= 1'b0;
            draw_mode   <= MODE_ERASE;
            draw_x      <= '0;
            draw_y      <= '0;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            last_status <= ST_TITLE;
            lat_status  <= ST_PLAY;
            lat_bypass  <= 1'b0;
            lat_prev_x  <= '0;
            lat_curr_x  <= '0;
            lat_curr_y  <= '0;
        end else begin
            draw_start <= cmd_go;
            if (cmd_go) begin
                draw_mode <= cmd_mode;
                draw_x    <= cmd_x;
                draw_y    <= cmd_y;
            end

            if (state == S_LATCH) begin
                lat_status <= game_status;
                lat_bypass <= bypass_erase;
                lat_prev_x <= prev_x;
                lat_curr_x <= curr_x;
                lat_curr_y <= curr_y;
                if (game_status != last_status) last_status <= game_status;
            end

            // IDLE consumes one queued tick; a fresh tick in the same cycle
            // starts this frame and the queued one stays for the next.
            if (state == S_IDLE) begin
                pending <= pending && tick;
            end else if (tick) begin
                pending <= 1'b1;
                if (pending) overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with FRAME_DIV=8 and a behavioural
// draw engine; expected cycles and commands are worked out by hand.
module tb_frame_sequencer;
    import frame_pkg::*;

    localparam int FRAME_DIV = 8;
    localparam int CNT_W     = 3;
    localparam int X_W       = 8;
    localparam int Y_W       = 7;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [1:0]     game_status;
    logic           bypass_erase;
    logic [X_W-1:0] prev_x;
    logic [X_W-1:0] curr_x;
    logic [Y_W-1:0] curr_y;
    logic           draw_done = 1'b0;
    logic           draw_start;
    logic [1:0]     draw_mode;
    logic [X_W-1:0] draw_x;
    logic [Y_W-1:0] draw_y;
    logic           sync;
    logic           busy;
    logic           overrun;
    logic [20:0]    outs;

    frame_sequencer #(
        .FRAME_DIV (FRAME_DIV),
        .CNT_W     (CNT_W),
        .X_W       (X_W),
        .Y_W       (Y_W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .game_status  (game_status),
        .bypass_erase (bypass_erase),
        .prev_x       (prev_x),
        .curr_x       (curr_x),
        .curr_y       (curr_y),
        .draw_done    (draw_done),
        .draw_start   (draw_start),
        .draw_mode    (draw_mode),
        .draw_x       (draw_x),
        .draw_y       (draw_y),
        .sync         (sync),
        .busy         (busy),
        .overrun      (overrun)
    );

    assign outs = {draw_start, draw_mode, draw_x, draw_y, sync, busy, overrun};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Engine model and event log, sampled just after each rising edge.
    int eng_delay    = 3;
    bit early_done   = 1'b0;
    int spurious_cyc = -1;
    int eng_cnt      = 0;
    bit prev_busy    = 1'b0;
    int n_cmd = 0, n_sync = 0, n_latch = 0;
    int cmd_mode_a[128], cmd_x_a[128], cmd_y_a[128], cmd_cyc_a[128];
    int sync_a[128], latch_a[128];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            draw_done = 1'b0;
            if (!resetn) begin
                eng_cnt = 0;
            end else begin
                if (busy && !prev_busy) begin
                    latch_a[n_latch % 128] = cyc;
                    n_latch++;
                end
                if (sync) begin
                    sync_a[n_sync % 128] = cyc;
                    n_sync++;
                end
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) draw_done = 1'b1;
                end
                if (cyc == spurious_cyc) draw_done = 1'b1;
                if (draw_start) begin
                    cmd_mode_a[n_cmd % 128] = int'(draw_mode);
                    cmd_x_a[n_cmd % 128]    = int'(draw_x);
                    cmd_y_a[n_cmd % 128]    = int'(draw_y);
                    cmd_cyc_a[n_cmd % 128]  = cyc;
                    n_cmd++;
                    eng_cnt = eng_delay;
                    if (early_done) draw_done = 1'b1;
                end
            end
            prev_busy = busy;
        end
    end

    task automatic check_cmd(input string tag, input int idx, input int m, input int x,
                             input int y, input int c);
        if (idx < n_cmd) begin
            check({tag, ".mode"}, cmd_mode_a[idx % 128], m);
            check({tag, ".x"},    cmd_x_a[idx % 128], x);
            check({tag, ".y"},    cmd_y_a[idx % 128], y);
            check({tag, ".cyc"},  cmd_cyc_a[idx % 128], c);
        end else begin
            check({tag, ".present"}, n_cmd, idx + 1);
        end
    endtask

    task automatic check_sync(input string tag, input int idx, input int c);
        if (idx < n_sync) check(tag, sync_a[idx % 128], c);
        else              check({tag, ".present"}, n_sync, idx + 1);
    endtask

    task automatic check_latch(input string tag, input int idx, input int c);
        if (idx < n_latch) check(tag, latch_a[idx % 128], c);
        else               check({tag, ".present"}, n_latch, idx + 1);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic apply_reset(output int rel);
        @(negedge clk);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        rel = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int r, c0, s0, l0;
        game_status  = ST_PLAY;
        bypass_erase = 1'b0;
        prev_x       = 8'd10;
        curr_x       = 8'd12;
        curr_y       = 7'd50;

        @(negedge clk);
        check("reset.outs", outs, 0);

        // Frame 1 clears (title -> play), frame 2 erases then draws.
        eng_delay = 3;
        apply_reset(r);
        c0 = n_cmd; s0 = n_sync; l0 = n_latch;
        wait_cyc(r + 30);
        check_latch("a.latch0", l0, r + 8);
        check_cmd("a.clear", c0, MODE_CLEAR, 0, 0, r + 9);
        check_cmd("a.sprite0", c0 + 1, MODE_SPRITE, 12, 50, r + 13);
        check_sync("a.sync0", s0, r + 17);
        check_latch("a.latch1", l0 + 1, r + 19);
        check_cmd("a.erase", c0 + 2, MODE_ERASE, 10, 50, r + 20);
        check_cmd("a.sprite1", c0 + 3, MODE_SPRITE, 12, 50, r + 24);
        check_sync("a.sync1", s0 + 1, r + 28);
        check("a.ncmd", n_cmd - c0, 4);

        // Bypass, mid-frame status change, status screens, spurious dones.
        eng_delay  = 1;
        early_done = 1'b1;
        apply_reset(r);
        c0 = n_cmd; s0 = n_sync; l0 = n_latch;
        spurious_cyc = r + 1;
        wait_cyc(r + 5);
        check("b.idle_spurious.busy", busy, 0);
        check("b.idle_spurious.ncmd", n_cmd - c0, 0);
        check("b.idle_spurious.nsync", n_sync - s0, 0);
        wait_cyc(r + 14);
        bypass_erase = 1'b1;
        wait_cyc(r + 20);
        bypass_erase = 1'b0;
        wait_cyc(r + 26);
        game_status = ST_LOSE;
        curr_x      = 8'd99;
        wait_cyc(r + 52);
        check_latch("b.latch0", l0, r + 8);
        check_cmd("b.clear", c0, MODE_CLEAR, 0, 0, r + 9);
        check_cmd("b.sprite0", c0 + 1, MODE_SPRITE, 12, 50, r + 11);
        check_sync("b.sync0", s0, r + 13);
        check_cmd("b.bypass_sprite", c0 + 2, MODE_SPRITE, 12, 50, r + 17);
        check_sync("b.sync_bypass", s0 + 1, r + 19);
        check_cmd("b.erase", c0 + 3, MODE_ERASE, 10, 50, r + 25);
        check_cmd("b.sprite_held", c0 + 4, MODE_SPRITE, 12, 50, r + 27);
        check_sync("b.sync2", s0 + 2, r + 29);
        check_cmd("b.lose_clear", c0 + 5, MODE_CLEAR, 0, 0, r + 33);
        check_cmd("b.lose_screen", c0 + 6, MODE_SCREEN, 0, 0, r + 35);
        check_sync("b.sync3", s0 + 3, r + 37);
        check_sync("b.sync_static0", s0 + 4, r + 41);
        check_sync("b.sync_static1", s0 + 5, r + 49);
        check_latch("b.latch5", l0 + 5, r + 48);
        check("b.ncmd", n_cmd - c0, 7);
        check("b.nsync", n_sync - s0, 6);
        check("b.overrun", overrun, 0);

        // Slow engine: pending, then overrun, queued frame, reset during ERASE.
        game_status  = ST_PLAY;
        curr_x       = 8'd12;
        eng_delay    = 20;
        early_done   = 1'b0;
        spurious_cyc = -1;
        apply_reset(r);
        c0 = n_cmd; s0 = n_sync; l0 = n_latch;
        wait_cyc(r + 22);
        check("c.overrun_after_first_extra", overrun, 0);
        wait_cyc(r + 24);
        check("c.overrun_after_second_extra", overrun, 1);
        wait_cyc(r + 56);
        check_cmd("c.clear", c0, MODE_CLEAR, 0, 0, r + 9);
        check_cmd("c.sprite", c0 + 1, MODE_SPRITE, 12, 50, r + 30);
        check_sync("c.sync0", s0, r + 51);
        check_latch("c.queued_latch", l0 + 1, r + 53);
        check_cmd("c.erase", c0 + 2, MODE_ERASE, 10, 50, r + 54);
        check("c.erase_busy", busy, 1);
        check("c.erase_mode_held", draw_mode, MODE_ERASE);
        resetn = 1'b0;
        #1;
        check("c.reset_async.outs", outs, 0);
        @(negedge clk);
        check("c.reset_edge.outs", outs, 0);
        repeat (2) @(negedge clk);
        check("c.reset.nsync", n_sync - s0, 1);
        check("c.reset.ncmd", n_cmd - c0, 3);
        eng_delay = 1;
        resetn = 1'b1;
        r = cyc;
        c0 = n_cmd; s0 = n_sync;
        wait_cyc(r + 16);
        check_cmd("c.post_reset_clear", c0, MODE_CLEAR, 0, 0, r + 9);
        check_cmd("c.post_reset_sprite", c0 + 1, MODE_SPRITE, 12, 50, r + 11);
        check_sync("c.post_reset_sync", s0, r + 13);
        check("c.post_reset_overrun", overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Central frame scheduler between game_logic_top and the VGA plotting datapath. Divides clk into frame ticks and sequences one frame as: erase old sprite, draw new sprite, then pulse sync to game logic. It owns the single draw engine through a start/done handshake, and inserts a full-screen clear whenever game_status changes. Overruns are flagged, never silently dropped.

Parameters:
FRAME_DIV, 833333, clk cycles per frame tick (50 MHz / 60 Hz); must be >= 2.
CNT_W, 20, width of the frame divider counter; must hold FRAME_DIV-1.
X_W, 8, x coordinate width (160-pixel screen).
Y_W, 7, y coordinate width (120-line screen).

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
game_status  in  2  00 play, 01 win, 10 lose, 11 title
bypass_erase  in  1  skip the erase phase this frame
prev_x  in  X_W  sprite x drawn last frame
curr_x  in  X_W  sprite x for this frame
curr_y  in  Y_W  sprite y for this frame
draw_done  in  1  one-cycle pulse from draw engine: command finished
draw_start  out  1  one-cycle command strobe to draw engine
draw_mode  out  2  00 ERASE, 01 SPRITE, 10 CLEAR, 11 SCREEN (status screen)
draw_x  out  X_W  command x
draw_y  out  Y_W  command y
sync  out  1  one-cycle pulse to game logic: frame done, advance state
busy  out  1  high whenever state != IDLE
overrun  out  1  sticky: a tick arrived while one was already pending

Behaviour:
- Reset (async, resetn=0): state IDLE, divider=0, pending=0, last_status=11. All outputs 0: draw_start, draw_mode, draw_x, draw_y, sync, busy, overrun.
- Divider: counts 0..FRAME_DIV-1 and wraps. Tick is high for one cycle when count==FRAME_DIV-1. The divider runs regardless of state.
- Tick in IDLE: go to LATCH next cycle.
- Tick outside IDLE: set pending. If pending is already 1, also set overrun (sticky until reset). At most one tick is queued.
- LATCH: register game_status, bypass_erase, prev_x, curr_x and curr_y. Inputs are sampled only here and ignored for the rest of the frame.
- After LATCH, the next state is chosen in this order:
  - Latched status != last_status: CLEAR, then last_status <= latched status.
  - Else status==00 and bypass_erase=0: ERASE.
  - Else status==00: SPRITE.
  - Else: DONE. Status screens are drawn only once, immediately after their CLEAR.
- Command states (ERASE, SPRITE, CLEAR, SCREEN):
  - On entry, assert draw_start for exactly 1 cycle with mode/x/y valid.
  - Hold draw_mode/x/y stable until draw_done is seen.
  - Coordinates per mode:
    - ERASE: (prev_x, curr_y).
    - SPRITE: (curr_x, curr_y).
    - CLEAR: (0,0).
    - SCREEN: (0,0).
  - draw_done in the same cycle as draw_start is ignored. The engine latency is >= 1 cycle.
  - draw_done while in IDLE, LATCH or DONE is ignored.
- Transitions on draw_done:
  - ERASE -> SPRITE.
  - SPRITE -> DONE.
  - CLEAR -> SPRITE if the latched status is 00.
  - CLEAR -> SCREEN if the latched status is nonzero.
  - SCREEN -> DONE.
- DONE: sync=1 for exactly one cycle, then IDLE.
- IDLE with pending=1: clear pending and go to LATCH. A queued tick starts the next frame without waiting for the divider.
- Timing: tick at cycle T gives LATCH at T+1 and draw_start at T+2. draw_done of the final command at cycle D gives sync at D+1.
- Simultaneous events:
  - A tick in the same cycle as DONE counts as outside IDLE and sets pending.
  - A tick in the same cycle as the state returns to IDLE from DONE is also handled as pending.
- Reset mid-frame: abort immediately. No sync pulse, no further draw_start. The draw engine is expected to share resetn.

Decomposition:
- Shared package frame_pkg holds:
  - draw_mode constants: MODE_ERASE, MODE_SPRITE, MODE_CLEAR, MODE_SCREEN.
  - game_status constants: ST_PLAY, ST_WIN, ST_LOSE, ST_TITLE.
  - state encoding localparams.
- One sub-module is natural: frame_tick_gen (divider plus tick output, parameters FRAME_DIV and CNT_W). The FSM stays in frame_sequencer.

Test Plan:
1. Reset, FRAME_DIV=8, status=00, bypass=0, prev_x=10, curr_x=12, curr_y=50, engine replies done 3 cycles after each start.
   - First frame: CLEAR(0,0), then SPRITE(12,50), then sync. last_status 11 -> 00 forces the CLEAR.
   - Second frame: ERASE(10,50), then SPRITE(12,50), then sync.
   - Tick-to-draw_start latency is 2 cycles.
2. Steady play with bypass_erase=1 at LATCH -> only SPRITE is issued, exactly one draw_start and one sync in the frame.
3. game_status 00 -> 10 mid-frame -> no effect that frame. Next frame: CLEAR, then SCREEN, then sync. Following frames with status still 10: sync only, zero draw_start.
4. Engine delays done 20 cycles with FRAME_DIV=8:
   - First extra tick sets pending without setting overrun.
   - Second extra tick sets overrun=1.
   - After sync, the next LATCH occurs with no wait for the divider.
5. Spurious draw_done while IDLE, and draw_done coincident with draw_start -> ignored, state unchanged, no extra sync.
6. Assert resetn=0 during ERASE -> next edge: all outputs 0, busy=0, overrun cleared. After release, the first frame issues CLEAR again.
